// File: rtl/uart_tx_engine.sv
// uart_tx_engine
//   Serializing UART transmit engine. Pops one word per frame from the TX
//   byte FIFO and sends start bit, data bits (LSB first), optional parity
//   and one or two stop bits, each held for CLKS_PER_BIT clocks.
//
// Ports
//   Clk        : clock, rising edge
//   Reset      : synchronous, active-high reset
//   tx_en      : permits starting a new frame (an active frame always completes)
//   fifo_data  : FIFO read data, valid the cycle after fifo_rd_en
//   fifo_empty : FIFO empty flag
//   fifo_rd_en : one-cycle combinational pop request
//   tx         : registered serial output, idles high
//   busy       : high whenever the engine is not idle
//   tx_done    : one-cycle pulse in the first idle cycle after the last stop bit
module uart_tx_engine #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  tx_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int SEL_W  = $clog2(DATA_WIDTH);
  localparam int IDX_W  = SEL_W + 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_WIDTH - 1);
  // The stop counter is one bit: value 1 is the last stop bit when two are sent.
  localparam logic              STOP_LAST = (STOP_BITS == 2);
  localparam logic              HAS_PAR   = (PARITY_EN != 0);
  localparam logic              ODD_PAR   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
  logic [BAUD_W-1:0]       baud_q, baud_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    stop_q, stop_d;
  logic                    tx_q, tx_d;
  logic                    done_q, done_d;

  logic                    bit_end;
  logic [BAUD_W-1:0]       baud_inc;
  logic [IDX_W-1:0]        idx_inc;

  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d);
    return (^d) ^ ODD_PAR;
  endfunction

  assign bit_end  = (baud_q == BAUD_LAST);
  assign baud_inc = baud_q + BAUD_W'(1);
  assign idx_inc  = idx_q + IDX_W'(1);

  // Pop is combinational so the FIFO word arrives in the FETCH cycle;
  // gating with Reset keeps a byte from being lost while the engine is held.
  assign fifo_rd_en = (state_q == S_IDLE) & tx_en & ~fifo_empty & ~Reset;
  assign busy       = (state_q != S_IDLE);
  assign tx         = tx_q;
  assign tx_done    = done_q;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    tx_d    = tx_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        idx_d  = '0;
        stop_d = 1'b0;
        if (fifo_rd_en) state_d = S_FETCH;
      end

      // fifo_empty lags the pop by a cycle, so it is not looked at here.
      S_FETCH: begin
        shreg_d = fifo_data;
        tx_d    = 1'b0;
        baud_d  = '0;
        state_d = S_START;
      end

      S_START: begin
        if (bit_end) begin
          baud_d  = '0;
          idx_d   = '0;
          tx_d    = shreg_q[0];
          state_d = S_DATA;
        end else begin
          baud_d = baud_inc;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (idx_q == IDX_LAST) begin
            stop_d = 1'b0;
            if (HAS_PAR) begin
              tx_d    = parity_bit(shreg_q);
              state_d = S_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            idx_d = idx_inc;
            tx_d  = shreg_q[idx_inc[SEL_W-1:0]];
          end
        end else begin
          baud_d = baud_inc;
        end
      end

      S_PARITY: begin
        if (bit_end) begin
          baud_d  = '0;
          stop_d  = 1'b0;
          tx_d    = 1'b1;
          state_d = S_STOP;
        end else begin
          baud_d = baud_inc;
        end
      end

      S_STOP: begin
        if (bit_end) begin
          baud_d = '0;
          if (stop_q == STOP_LAST) begin
            done_d  = 1'b1;
            stop_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end else begin
          baud_d = baud_inc;
        end
      end

      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  // Frame data register carries no reset; it is always reloaded in FETCH.
  always_ff @(posedge Clk) begin
    shreg_q <= shreg_d;
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine
//   Directed bench for uart_tx_engine. Three instances share the clock:
//   u0 is 8N1, u1 is 8E2, u2 is 8O2, all with four clocks per bit. Each has
//   a small behavioural FIFO; bytes written to a FIFO are also queued as the
//   expected frame contents and popped when the frame is observed on tx.
module tb_uart_tx_engine;
  localparam int CPB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       en0, en1, en2;
  logic [7:0] fd0, fd1, fd2;
  logic       emp0, emp1, emp2;
  logic       rd0, rd1, rd2;
  logic       tx0, tx1, tx2;
  logic       bz0, bz1, bz2;
  logic       dn0, dn1, dn2;

  logic [7:0] mem0 [16];
  logic [7:0] mem1 [16];
  logic [7:0] mem2 [16];
  int pu0, pu1, pu2;
  int po0, po1, po2;

  int cyc;
  int rdcnt0;
  int consec;
  logic [2:0] rd_prev;

  int checks;
  int errors;
  int sel;
  logic mtx, mbz, mdn, mrd;
  logic [7:0] exp_q [$];

  assign emp0 = (pu0 == po0);
  assign emp1 = (pu1 == po1);
  assign emp2 = (pu2 == po2);

  uart_tx_engine #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1),
                   .PARITY_EN(0), .PARITY_ODD(0)) u0 (
    .Clk(clk), .Reset(rst), .tx_en(en0), .fifo_data(fd0), .fifo_empty(emp0),
    .fifo_rd_en(rd0), .tx(tx0), .busy(bz0), .tx_done(dn0));

  uart_tx_engine #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2),
                   .PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .Clk(clk), .Reset(rst), .tx_en(en1), .fifo_data(fd1), .fifo_empty(emp1),
    .fifo_rd_en(rd1), .tx(tx1), .busy(bz1), .tx_done(dn1));

  uart_tx_engine #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2),
                   .PARITY_EN(1), .PARITY_ODD(1)) u2 (
    .Clk(clk), .Reset(rst), .tx_en(en2), .fifo_data(fd2), .fifo_empty(emp2),
    .fifo_rd_en(rd2), .tx(tx2), .busy(bz2), .tx_done(dn2));

  // FIFO read ports: data appears the cycle after the pop.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd0) begin fd0 <= mem0[po0 % 16]; po0 <= po0 + 1; rdcnt0 <= rdcnt0 + 1; end
    if (rd1) begin fd1 <= mem1[po1 % 16]; po1 <= po1 + 1; end
    if (rd2) begin fd2 <= mem2[po2 % 16]; po2 <= po2 + 1; end
    rd_prev <= {rd2, rd1, rd0};
    if (|({rd2, rd1, rd0} & rd_prev)) consec <= consec + 1;
  end

  always_comb begin
    mtx = tx0; mbz = bz0; mdn = dn0; mrd = rd0;
    if (sel == 1) begin
      mtx = tx1; mbz = bz1; mdn = dn1; mrd = rd1;
    end else if (sel == 2) begin
      mtx = tx2; mbz = bz2; mdn = dn2; mrd = rd2;
    end
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int w, input logic [7:0] b);
    case (w)
      0: begin mem0[pu0 % 16] = b; pu0++; end
      1: begin mem1[pu1 % 16] = b; pu1++; end
      default: begin mem2[pu2 % 16] = b; pu2++; end
    endcase
    exp_q.push_back(b);
  endtask

  // Line levels of a whole frame: bit 0 start, 1..8 data LSB first,
  // 9 parity when enabled, everything above is stop level.
  function automatic logic [15:0] mkbits(input logic [7:0] b, input logic par, input logic odd);
    logic [15:0] r;
    int ones;
    r = '1;
    r[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      r[1 + i] = b[i];
      if (b[i]) ones++;
    end
    if (par) r[9] = ((ones % 2) == 1) ^ odd;
    return r;
  endfunction

  // Returns at negedge+1 of the cycle in which the selected pop is high.
  task automatic wait_pop(output int pc);
    int i;
    i = 0;
    #1;
    while (mrd !== 1'b1 && i < 300) begin
      @(negedge clk);
      #1;
      i++;
    end
    chk1("pop_seen", mrd, 1'b1);
    pc = cyc;
  endtask

  // Called in the pop cycle; ends at the negedge of the tx_done cycle.
  task automatic frame(input int nb, input bit drop, input string tag);
    logic [7:0]  b;
    logic [15:0] bits;
    logic        bad, cbad;
    b = 8'hxx;
    if (exp_q.size() > 0) b = exp_q.pop_front();
    bits = mkbits(b, sel != 0, sel == 2);
    @(negedge clk);
    chk1($sformatf("%s_fetch_busy", tag), mbz, 1'b1);
    chk1($sformatf("%s_fetch_tx", tag), mtx, 1'b1);
    @(negedge clk);
    for (int k = 0; k < nb; k++) begin
      bad = 1'b0;
      cbad = 1'b0;
      for (int c = 0; c < CPB; c++) begin
        if (mtx !== bits[k]) bad = 1'b1;
        if (mdn !== 1'b0 || mbz !== 1'b1 || mrd !== 1'b0) cbad = 1'b1;
        if (drop && k == 4 && c == 0) en0 = 1'b0;
        @(negedge clk);
      end
      chk1($sformatf("%s_bit%0d_level", tag, k), bad, 1'b0);
      chk1($sformatf("%s_bit%0d_ctrl", tag, k), cbad, 1'b0);
    end
    chk1($sformatf("%s_done", tag), mdn, 1'b1);
    chk1($sformatf("%s_done_busy", tag), mbz, 1'b0);
    chk1($sformatf("%s_done_tx", tag), mtx, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   p, p1, p2, p3, r0;
    logic bad;
    rst = 1'b1;
    en0 = 1'b0; en1 = 1'b0; en2 = 1'b0;
    sel = 0;
    repeat (3) @(negedge clk);

    // Reset values
    chk1("rst_tx", tx0, 1'b1);
    chk1("rst_busy", bz0, 1'b0);
    chk1("rst_done", dn0, 1'b0);
    chk1("rst_rd", rd0, 1'b0);
    chk1("rst_tx_par", tx1, 1'b1);
    rst = 1'b0;

    // Single 8N1 frame
    push(0, 8'hA5);
    en0 = 1'b1;
    wait_pop(p);
    frame(10, 1'b0, "a5");
    chkn("a5_done_cycle", cyc - p, 42);
    chk1("a5_no_more_pop", mrd, 1'b0);

    // Back-to-back frames
    @(negedge clk);
    r0 = rdcnt0;
    push(0, 8'h00);
    push(0, 8'hFF);
    push(0, 8'h3C);
    wait_pop(p1);
    frame(10, 1'b0, "b0");
    chk1("b0_pop_with_done", mrd, 1'b1);
    p2 = cyc;
    chkn("b01_period", p2 - p1, 42);
    frame(10, 1'b0, "b1");
    chk1("b1_pop_with_done", mrd, 1'b1);
    p3 = cyc;
    chkn("b12_period", p3 - p2, 42);
    frame(10, 1'b0, "b2");
    chk1("b2_no_pop", mrd, 1'b0);
    @(negedge clk);
    chk1("b_after_busy", mbz, 1'b0);
    chk1("b_after_tx", mtx, 1'b1);
    chkn("b_pop_count", rdcnt0 - r0, 3);

    // Parity with two stop bits: even, then odd
    en0 = 1'b0;
    sel = 1;
    push(1, 8'h07);
    en1 = 1'b1;
    wait_pop(p);
    frame(12, 1'b0, "par_even");
    chkn("par_even_len", cyc - p, 50);
    en1 = 1'b0;
    sel = 2;
    push(2, 8'h07);
    en2 = 1'b1;
    wait_pop(p);
    frame(12, 1'b0, "par_odd");
    chkn("par_odd_len", cyc - p, 50);
    en2 = 1'b0;

    // Flow gating
    sel = 0;
    r0 = rdcnt0;
    push(0, 8'h55);
    bad = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (rd0 !== 1'b0 || tx0 !== 1'b1) bad = 1'b1;
    end
    chk1("gate_hold", bad, 1'b0);
    chkn("gate_no_pop", rdcnt0 - r0, 0);
    push(0, 8'h66);
    en0 = 1'b1;
    wait_pop(p);
    frame(10, 1'b1, "gate");
    bad = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (rd0 !== 1'b0 || tx0 !== 1'b1 || bz0 !== 1'b0) bad = 1'b1;
    end
    chk1("gate_after_drop", bad, 1'b0);
    chkn("gate_pop_count", rdcnt0 - r0, 1);

    // Reset in DATA bit 3; 0x66 is lost, 0x3A follows after release
    en0 = 1'b1;
    wait_pop(p);
    push(0, 8'h3A);
    @(negedge clk);
    @(negedge clk);
    repeat (16) @(negedge clk);
    chk1("rst_mid_busy_before", bz0, 1'b1);
    chk1("rst_mid_bit3", tx0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk1("rst_mid_tx", tx0, 1'b1);
    chk1("rst_mid_busy", bz0, 1'b0);
    chk1("rst_mid_done", dn0, 1'b0);
    chk1("rst_mid_rd", rd0, 1'b0);
    @(negedge clk);
    chk1("rst_mid_done2", dn0, 1'b0);
    chk1("rst_mid_rd2", rd0, 1'b0);
    void'(exp_q.pop_front());
    rst = 1'b0;
    wait_pop(p);
    frame(10, 1'b0, "post_rst");

    // Empty FIFO
    @(negedge clk);
    r0 = rdcnt0;
    bad = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      if (rd0 !== 1'b0 || tx0 !== 1'b1) bad = 1'b1;
    end
    chk1("empty_idle", bad, 1'b0);
    chkn("empty_no_pop", rdcnt0 - r0, 0);

    chkn("pop_never_consecutive", consec, 0);
    chkn("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
